// File: rtl/avalon_master_bridge.sv
// CPU load/store to Avalon-MM master bridge: byte/half/word access with lane
// steering, load extension, misalignment trap and stall timeout.
module avalon_master_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        cpu_timeout,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] writedata
);
    typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   address_q, address_d;
    logic [3:0]    byteenable_q, byteenable_d;
    logic [31:0]   writedata_q, writedata_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          req_misaligned;
    logic [3:0]    req_be;
    logic [31:0]   req_wd;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_value;

    // Request decode straight from the CPU inputs, used only at acceptance.
    always_comb begin
        req_misaligned = (cpu_size == 2'b11)
                      || (cpu_size == 2'b01 && cpu_addr[0])
                      || (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);
        case (cpu_size)
            2'b00: begin
                req_be = 4'b0001 << cpu_addr[1:0];
                req_wd = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                req_be = cpu_addr[1] ? 4'b1100 : 4'b0011;
                req_wd = {2{cpu_wdata[15:0]}};
            end
            2'b10: begin
                req_be = 4'b1111;
                req_wd = cpu_wdata;
            end
            default: begin
                req_be = 4'b0000;
                req_wd = cpu_wdata;
            end
        endcase
    end

    // Load extraction uses the captured request, since cpu_* may change during BUS.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = readdata[7:0];
            2'd1:    ld_byte = readdata[15:8];
            2'd2:    ld_byte = readdata[23:16];
            default: ld_byte = readdata[31:24];
        endcase
        ld_half = lane_q[1] ? readdata[31:16] : readdata[15:0];
        case (size_q)
            2'b00:   ld_value = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_value = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_value = readdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        address_d    = address_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        read_d       = read_q;
        write_d      = write_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d         = cpu_we;
                    size_d       = cpu_size;
                    signed_d     = cpu_signed;
                    lane_d       = cpu_addr[1:0];
                    address_d    = {cpu_addr[31:2], 2'b00};
                    byteenable_d = req_be;
                    writedata_d  = req_wd;
                    stall_cnt_d  = '0;
                    if (req_misaligned) begin
                        state_d = ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUS;
                        read_d  = ~cpu_we;
                        write_d = cpu_we;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = ld_value;
                    end
                end else if (stall_cnt_q == STALL_LAST) begin
                    state_d   = DONE;
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            stall_cnt_q  <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            address_q    <= '0;
            byteenable_q <= '0;
            writedata_q  <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            address_q    <= address_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            rdata_q      <= rdata_d;
        end
    end

    assign cpu_busy    = busy_q;
    assign cpu_done    = done_q;
    assign cpu_rdata   = rdata_q;
    assign cpu_err     = err_q;
    assign cpu_timeout = timeout_q;
    assign address     = address_q;
    assign byteenable  = byteenable_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
endmodule

// File: tb/tb_avalon_master_bridge.sv
// Bench for avalon_master_bridge: directed scenarios plus randomized accesses
// checked against an arithmetic model of lane selection and extension.
module tb_avalon_master_bridge;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_signed;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_busy, cpu_done, cpu_err, cpu_timeout;
    logic [31:0] cpu_rdata, address, writedata, readdata;
    logic [3:0]  byteenable;
    logic        read, write, waitrequest;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent transaction
    int          o_done_cycle, o_done_cnt, o_strobe;
    logic        o_overlap, o_unstable, o_read_seen, o_write_seen, o_err, o_timeout;
    logic [31:0] o_addr, o_wd, o_rdata;
    logic [3:0]  o_be;
    logic [31:0] exp_rdata;

    avalon_master_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err), .cpu_timeout(cpu_timeout),
        .address(address), .byteenable(byteenable), .read(read), .write(write),
        .waitrequest(waitrequest), .readdata(readdata), .writedata(writedata)
    );

    always #5 clk = ~clk;

    function automatic logic m_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] size);
        int unsigned lane = addr % 4;
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return 4'(3 << (2 * (lane / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] wdata, input logic [1:0] size);
        if (size == 2'd0) return (wdata & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h00010001;
        return wdata;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [1:0] size, input logic sgn);
        int unsigned lane = addr % 4;
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rd >> (8 * lane)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v - 32'h100;
        end else if (size == 2'd1) begin
            v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Issue one request from an idle slot and act as the slave; observations land in o_*.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata, input logic [31:0] rd,
                           input int stalls);
        int bus_n = 0;
        o_done_cycle = -1; o_done_cnt = 0; o_strobe = 0;
        o_overlap = 0; o_unstable = 0; o_read_seen = 0; o_write_seen = 0;
        o_err = 0; o_timeout = 0; o_rdata = cpu_rdata;
        o_addr = '0; o_be = '0; o_wd = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size;
        cpu_signed = sgn; cpu_wdata = wdata; readdata = rd; waitrequest = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            if (read && write) o_overlap = 1'b1;
            if (read || write) begin
                if (o_strobe == 0) begin
                    o_addr = address; o_be = byteenable; o_wd = writedata;
                end else if (address !== o_addr || byteenable !== o_be || writedata !== o_wd) begin
                    o_unstable = 1'b1;
                end
                o_strobe++;
                if (read)  o_read_seen = 1'b1;
                if (write) o_write_seen = 1'b1;
                bus_n++;
                waitrequest = (bus_n <= stalls);
            end else begin
                waitrequest = 1'b0;
            end
            if (cpu_done) begin
                o_done_cnt++;
                if (o_done_cycle < 0) begin
                    o_done_cycle = n; o_err = cpu_err; o_timeout = cpu_timeout; o_rdata = cpu_rdata;
                end
            end
            if (o_done_cycle > 0 && n >= o_done_cycle + 2) break;
        end
        waitrequest = 1'b0;
        $display("txn we=%0b addr=%08h size=%0d sgn=%0b stalls=%0d done_cycle=%0d strobe=%0d be=%b rdata=%08h",
                 we, addr, size, sgn, stalls, o_done_cycle, o_strobe, o_be, o_rdata);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({read, write, cpu_busy, cpu_done, cpu_err, cpu_timeout} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {read, write, cpu_busy, cpu_done, cpu_err, cpu_timeout}); end
        n_checks++; if (address !== 32'h0) begin n_fail++; $display("FAIL reset_address: got %08h expected 0", address); end
        n_checks++; if (byteenable !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %b expected 0000", byteenable); end
        n_checks++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %08h expected 0", writedata); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %08h expected 0", cpu_rdata); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, 32'h1003, 2'b00, 1'b1, 32'h0, 32'h80FFFFFF, 0);
        exp_rdata = 32'hFFFFFF80;
        n_checks++; if (o_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_address: got %08h expected 00001000", o_addr); end
        n_checks++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b expected 1000", o_be); end
        n_checks++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL lb_rdata: got %08h expected %08h", o_rdata, exp_rdata); end
        n_checks++; if (o_done_cycle != 2) begin n_fail++; $display("FAIL lb_latency: got %0d expected 2", o_done_cycle); end
        n_checks++; if (o_read_seen !== 1'b1 || o_write_seen !== 1'b0 || o_strobe != 1) begin n_fail++; $display("FAIL lb_strobe: got rd=%0b wr=%0b cycles=%0d expected rd=1 wr=0 cycles=1", o_read_seen, o_write_seen, o_strobe); end
    endtask

    task automatic test_store_half();
        run_txn(1'b1, 32'h2002, 2'b01, 1'b0, 32'h0000BEEF, $urandom, 3);
        n_checks++; if (o_strobe != 4 || o_write_seen !== 1'b1 || o_read_seen !== 1'b0) begin n_fail++; $display("FAIL sh_write_cycles: got %0d wr=%0b rd=%0b expected 4 wr=1 rd=0", o_strobe, o_write_seen, o_read_seen); end
        n_checks++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b expected 1100", o_be); end
        n_checks++; if (o_wd !== 32'hBEEFBEEF || o_unstable !== 1'b0) begin n_fail++; $display("FAIL sh_wdata: got %08h unstable=%0b expected BEEFBEEF unstable=0", o_wd, o_unstable); end
        n_checks++; if (o_done_cnt != 1 || o_done_cycle != 5) begin n_fail++; $display("FAIL sh_done: got count=%0d cycle=%0d expected count=1 cycle=5", o_done_cnt, o_done_cycle); end
        n_checks++; if (o_err !== 1'b0 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL sh_flags: got err=%0b to=%0b expected 0 0", o_err, o_timeout); end
        n_checks++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL sh_rdata_hold: got %08h expected %08h", o_rdata, exp_rdata); end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 32'h0006, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 0);
        n_checks++; if (o_strobe != 0) begin n_fail++; $display("FAIL mis_no_bus: got %0d strobe cycles expected 0", o_strobe); end
        n_checks++; if (o_done_cycle != 1 || o_done_cnt != 1) begin n_fail++; $display("FAIL mis_done: got cycle=%0d count=%0d expected cycle=1 count=1", o_done_cycle, o_done_cnt); end
        n_checks++; if (o_err !== 1'b1 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL mis_err: got err=%0b to=%0b expected 1 0", o_err, o_timeout); end
        n_checks++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL mis_rdata_hold: got %08h expected %08h", o_rdata, exp_rdata); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h0040, 2'b10, 1'b0, 32'h0, 32'h11223344, 1000);
        n_checks++; if (o_strobe != 16 || o_read_seen !== 1'b1) begin n_fail++; $display("FAIL to_read_cycles: got %0d expected 16", o_strobe); end
        n_checks++; if (o_done_cycle != 17 || o_done_cnt != 1) begin n_fail++; $display("FAIL to_done: got cycle=%0d count=%0d expected cycle=17 count=1", o_done_cycle, o_done_cnt); end
        n_checks++; if (o_timeout !== 1'b1 || o_err !== 1'b0) begin n_fail++; $display("FAIL to_flag: got to=%0b err=%0b expected 1 0", o_timeout, o_err); end
        n_checks++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL to_rdata_hold: got %08h expected %08h", o_rdata, exp_rdata); end
    endtask

    task automatic test_load_half();
        run_txn(1'b0, 32'h0010, 2'b01, 1'b0, 32'h0, 32'h1234F00D, 0);
        exp_rdata = 32'h0000F00D;
        n_checks++; if (o_be !== 4'b0011) begin n_fail++; $display("FAIL lh_be: got %b expected 0011", o_be); end
        n_checks++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL lh_rdata: got %08h expected %08h", o_rdata, exp_rdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        spurious = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0020; cpu_size = 2'b10;
        cpu_signed = 1'b0; readdata = 32'hCAFEF00D; waitrequest = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0; waitrequest = 1'b1;
        n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL rm_read_start: got %0b expected 1", read); end
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({read, write, cpu_busy, cpu_done, cpu_err, cpu_timeout} !== 6'b0) begin n_fail++; $display("FAIL rm_flags: got %b expected 000000", {read, write, cpu_busy, cpu_done, cpu_err, cpu_timeout}); end
        n_checks++; if ({address, writedata, cpu_rdata} !== 96'h0 || byteenable !== 4'h0) begin n_fail++; $display("FAIL rm_buses: got addr=%08h be=%b wd=%08h rdata=%08h expected all 0", address, byteenable, writedata, cpu_rdata); end
        reset_n = 1'b1; waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (cpu_done) spurious = 1'b1;
        end
        n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got done pulse expected none"); end
        exp_rdata = 32'h0;
        rd = $urandom;
        run_txn(1'b0, 32'h0031, 2'b00, 1'b0, 32'h0, rd, 1);
        exp_rdata = m_load(rd, 32'h0031, 2'b00, 1'b0);
        n_checks++; if (o_done_cycle != 3 || o_rdata !== exp_rdata) begin n_fail++; $display("FAIL rm_recover: got cycle=%0d rdata=%08h expected cycle=3 rdata=%08h", o_done_cycle, o_rdata, exp_rdata); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [31:0] addr, wdata, rd;
            logic [1:0]  size;
            logic        we, sgn, mis;
            int          stalls;
            addr = $urandom; wdata = $urandom; rd = $urandom;
            size = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1)); stalls = $urandom_range(0, 4);
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd2) addr = addr & ~32'h3;
                if (size == 2'd1) addr = addr & ~32'h1;
            end
            mis = m_misaligned(addr, size);
            run_txn(we, addr, size, sgn, wdata, rd, stalls);
            if (!mis && !we) exp_rdata = m_load(rd, addr, size, sgn);
            n_checks++; if (o_done_cycle != (mis ? 1 : 2 + stalls) || o_done_cnt != 1) begin n_fail++; $display("FAIL rnd_done[%0d]: got cycle=%0d count=%0d expected cycle=%0d count=1", t, o_done_cycle, o_done_cnt, mis ? 1 : 2 + stalls); end
            n_checks++; if (o_err !== mis || o_timeout !== 1'b0) begin n_fail++; $display("FAIL rnd_flags[%0d]: got err=%0b to=%0b expected err=%0b to=0", t, o_err, o_timeout, mis); end
            n_checks++; if (o_strobe != (mis ? 0 : 1 + stalls) || o_read_seen !== (!mis && !we) || o_write_seen !== (!mis && we) || o_overlap !== 1'b0) begin n_fail++; $display("FAIL rnd_strobe[%0d]: got cycles=%0d rd=%0b wr=%0b overlap=%0b", t, o_strobe, o_read_seen, o_write_seen, o_overlap); end
            n_checks++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %08h expected %08h", t, o_rdata, exp_rdata); end
            if (!mis) begin
                n_checks++; if (o_addr !== (addr & ~32'h3) || o_be !== m_be(addr, size) || o_unstable !== 1'b0) begin n_fail++; $display("FAIL rnd_bus[%0d]: got addr=%08h be=%b unstable=%0b expected addr=%08h be=%b", t, o_addr, o_be, o_unstable, addr & ~32'h3, m_be(addr, size)); end
                if (we) begin
                    n_checks++; if (o_wd !== m_wd(wdata, size)) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %08h expected %08h", t, o_wd, m_wd(wdata, size)); end
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = '0;
        cpu_signed = 1'b0; cpu_wdata = '0; waitrequest = 1'b0; readdata = '0;
        exp_rdata = '0;
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_load_half();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
